ram_clear_param: RTL and testbench

Parametrised successor to the fixed-size Hack RAM blocks (RAM8 … RAM16K), with configurable word width, depth and read latency. Adds a hardware clear sequencer that zeroes every word after reset or on request, and a `ready` flag that reports when the sequencer is idle. Sits on the data-memory side of the Hack CPU and drops in for any RAMn when `READ_LATENCY=0`.

---
 rtl/ram_pkg.sv | 12 +
 rtl/ram_clear_seq.sv | 60 ++++++
 rtl/ram_clear_param.sv | 71 +++++++
 tb/tb_ram_clear_param.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared types and encodings for the parametrised clearable Hack RAM.
package ram_pkg;

   typedef enum logic [0:0] {
      CLEAR,
      IDLE
   } ram_state_t;

   localparam int unsigned RD_COMB = 0;
   localparam int unsigned RD_REG  = 1;

endpackage

// File: rtl/ram_clear_seq.sv
// Clear sequencer: sweeps a zero write across every address after reset or on request.
module ram_clear_seq
   import ram_pkg::*;
#(
   parameter int unsigned ADDR_W = 6
) (
   input  logic              CLK,
   input  logic              reset,
   input  logic              clear,
   output logic              clr_we,
   output logic [ADDR_W-1:0] clr_addr,
   output logic              ready
);

   localparam logic [ADDR_W-1:0] LastPtr = '1;

   ram_state_t        state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;

   always_ff @(posedge CLK) begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      if (reset) begin
         state_d = CLEAR;
         ptr_d   = '0;
      end else begin
         case (state_q)
            // End on the explicit last-address compare rather than on wrap.
            CLEAR: begin
               if (ptr_q == LastPtr) begin
                  state_d = IDLE;
                  ptr_d   = '0;
               end else begin
                  ptr_d = ptr_q + ADDR_W'(1);
               end
            end
            IDLE: begin
               if (clear) begin
                  state_d = CLEAR;
                  ptr_d   = '0;
               end
            end
            default: begin
               state_d = CLEAR;
               ptr_d   = '0;
            end
         endcase
      end
   end

   assign clr_we   = (state_q == CLEAR);
   assign clr_addr = ptr_q;
   assign ready    = (state_q == IDLE);

endmodule

// File: rtl/ram_clear_param.sv
// Parametrised Hack-style RAM with hardware clear sweep and selectable read latency.
module ram_clear_param
   import ram_pkg::*;
#(
   parameter int unsigned WIDTH        = 16,
   parameter int unsigned ADDR_W       = 6,
   parameter int unsigned READ_LATENCY = RD_COMB
) (
   input  logic              CLK,
   input  logic              reset,
   input  logic [WIDTH-1:0]  in,
   input  logic              load,
   input  logic [ADDR_W-1:0] address,
   input  logic              clear,
   output logic [WIDTH-1:0]  out,
   output logic              ready
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic              clr_we;
   logic [ADDR_W-1:0] clr_addr;
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [WIDTH-1:0]  wdata;
   logic [WIDTH-1:0]  mem_q [DEPTH];

   ram_clear_seq #(
      .ADDR_W(ADDR_W)
   ) u_seq (
      .CLK     (CLK),
      .reset   (reset),
      .clear   (clear),
      .clr_we  (clr_we),
      .clr_addr(clr_addr),
      .ready   (ready)
   );

   // User writes only land in IDLE, and lose to a same-cycle clear or reset.
   always_comb begin
      we    = clr_we | (ready & load & ~clear & ~reset);
      waddr = clr_we ? clr_addr : address;
      wdata = clr_we ? '0 : in;
   end

   always_ff @(posedge CLK) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   generate
      if (READ_LATENCY == RD_REG) begin : g_rd_reg
         logic [WIDTH-1:0] out_q;

         // Read-first: the nonblocking read sees the pre-write contents.
         always_ff @(posedge CLK) begin
            if (reset || !ready) begin
               out_q <= '0;
            end else begin
               out_q <= mem_q[address];
            end
         end

         assign out = ready ? out_q : '0;
      end else begin : g_rd_comb
         assign out = ready ? mem_q[address] : '0;
      end
   endgenerate

endmodule

// File: tb/tb_ram_clear_param.sv
// Directed scoreboard bench: combinational, registered and narrow instances of the clearable RAM.
module tb_ram_clear_param;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic        reset, load, clear;
   logic [15:0] in;
   logic [5:0]  address;
   logic [15:0] out0, out1;
   logic        ready0, ready1;

   logic        reset2, load2, clear2;
   logic [7:0]  in2;
   logic [3:0]  address2;
   logic [7:0]  out2;
   logic        ready2;

   ram_clear_param #(.WIDTH(16), .ADDR_W(6), .READ_LATENCY(0)) u_comb (
      .CLK(CLK), .reset(reset), .in(in), .load(load), .address(address),
      .clear(clear), .out(out0), .ready(ready0)
   );

   ram_clear_param #(.WIDTH(16), .ADDR_W(6), .READ_LATENCY(1)) u_reg (
      .CLK(CLK), .reset(reset), .in(in), .load(load), .address(address),
      .clear(clear), .out(out1), .ready(ready1)
   );

   ram_clear_param #(.WIDTH(8), .ADDR_W(4), .READ_LATENCY(0)) u_small (
      .CLK(CLK), .reset(reset2), .in(in2), .load(load2), .address(address2),
      .clear(clear2), .out(out2), .ready(ready2)
   );

   int          n_checks = 0;
   int          n_errors = 0;
   logic [15:0] model [64];
   logic [15:0] q_reg [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk_reg_pop(input string tag);
      if (q_reg.size() == 0) begin
         chk({tag, "_empty_queue"}, 32'd1, 32'd0);
      end else begin
         chk(tag, 32'(out1), 32'(q_reg.pop_front()));
      end
   endtask

   task automatic rd_step(input logic [5:0] a);
      address = a;
      load    = 1'b0;
      clear   = 1'b0;
      #1;
      chk("rd_comb", 32'(out0), 32'(model[a]));
      q_reg.push_back(model[a]);
      tick();
      chk_reg_pop("rd_reg");
   endtask

   task automatic wr_step(input logic [5:0] a, input logic [15:0] d);
      address = a;
      in      = d;
      load    = 1'b1;
      clear   = 1'b0;
      q_reg.push_back(model[a]);
      tick();
      model[a] = d;
      load     = 1'b0;
      chk("wr_comb", 32'(out0), 32'(d));
      chk_reg_pop("wr_reg_readfirst");
   endtask

   task automatic count_sweep(inout int n);
      while (!ready0 && n < 200) begin
         tick();
         n++;
      end
   endtask

   task automatic zero_model();
      for (int i = 0; i < 64; i++) model[i] = 16'h0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      reset = 1'b1; load = 1'b0; clear = 1'b0; in = '0; address = '0;
      reset2 = 1'b1; load2 = 1'b0; clear2 = 1'b0; in2 = '0; address2 = '0;

      // Reset sweep.
      tick();
      reset = 1'b0;
      chk("rst_ready_comb", 32'(ready0), 32'd0);
      chk("rst_ready_reg", 32'(ready1), 32'd0);
      chk("rst_out_comb", 32'(out0), 32'd0);
      chk("rst_out_reg", 32'(out1), 32'd0);
      n = 0;
      count_sweep(n);
      chk("reset_sweep_len", 32'(n), 32'd64);
      chk("reset_ready_reg", 32'(ready1), 32'd1);
      chk("first_idle_out_reg", 32'(out1), 32'd0);
      zero_model();
      for (int i = 0; i < 64; i++) rd_step(6'(i));

      // Fill and read back.
      for (int i = 0; i < 64; i++) wr_step(6'(i), 16'(i));
      for (int i = 0; i < 64; i++) rd_step(6'(i));

      // Clear request, mid-sweep load and mid-sweep clear both ignored.
      wr_step(6'd5, 16'hBEEF);
      address = 6'd5; in = 16'hDEAD; load = 1'b1; clear = 1'b1;
      tick();
      load = 1'b0; clear = 1'b0;
      chk("clr_ready", 32'(ready0), 32'd0);
      chk("clr_out_comb", 32'(out0), 32'd0);
      chk("clr_out_reg", 32'(out1), 32'd0);
      n = 0;
      repeat (9) begin
         tick();
         n++;
      end
      address = 6'd7; in = 16'h1234; load = 1'b1;
      tick();
      n++;
      load = 1'b0; clear = 1'b1;
      tick();
      n++;
      clear = 1'b0;
      chk("mid_sweep_out_reg", 32'(out1), 32'd0);
      count_sweep(n);
      chk("clear_sweep_len", 32'(n), 32'd64);
      zero_model();
      chk("post_clear_out_reg", 32'(out1), 32'd0);
      rd_step(6'd5);
      rd_step(6'd7);

      // Reset at sweep cycle 30 restarts the sweep.
      wr_step(6'd9, 16'h55AA);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      repeat (29) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n = 0;
      count_sweep(n);
      chk("restart_sweep_len", 32'(n), 32'd64);
      zero_model();
      wr_step(6'd9, 16'h0042);
      rd_step(6'd9);
      rd_step(6'd10);

      // Read-first at the registered port.
      wr_step(6'd3, 16'd10);
      wr_step(6'd3, 16'd20);
      rd_step(6'd3);

      // Narrow, shallow instance.
      tick();
      reset2 = 1'b0;
      n = 0;
      while (!ready2 && n < 200) begin
         tick();
         n++;
      end
      chk("small_sweep_len", 32'(n), 32'd16);
      address2 = 4'd15; in2 = 8'hFF; load2 = 1'b1;
      tick();
      load2 = 1'b0;
      chk("small_wr15", 32'(out2), 32'hFF);
      address2 = 4'd0;
      #1;
      chk("small_rd0", 32'(out2), 32'd0);
      address2 = 4'd15;
      #1;
      chk("small_rd15", 32'(out2), 32'hFF);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
